// File: rtl/adc_capture_engine.sv
// adc_capture_engine: programmable ADC sample-clock generator, sample capture,
// power-of-two averaging and a first-word-fall-through result FIFO with sticky
// overflow. Everything runs on I_clk.
module adc_capture_engine #(
  parameter int DATA_W  = 12,
  parameter int DIV_W   = 16,
  parameter int FIFO_AW = 4
) (
  input  logic               I_clk,
  input  logic               I_rst,
  input  logic               I_enable,
  input  logic [DATA_W-1:0]  I_adc_data,
  input  logic [DIV_W-1:0]   I_div_setting,
  input  logic [1:0]         I_avg_log2,
  input  logic               I_cfg_valid,
  input  logic               I_rd_ready,
  input  logic               I_clr_overflow,
  output logic               O_adc_clk,
  output logic               O_rd_valid,
  output logic [DATA_W-1:0]  O_rd_data,
  output logic [FIFO_AW:0]   O_fifo_level,
  output logic               O_overflow
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int ACC_W = DATA_W + 3;

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [DIV_W-1:0]   n_act_q, pend_n_q;
  logic [1:0]         a_act_q, pend_a_q;
  logic               pend_vld_q;
  logic               adc_clk_q;
  logic               phase_end, strobe, apply_cfg, cfg_take, to_idle;

  logic [DATA_W-1:0]  sample_q;
  logic               sample_vld_q;
  logic [ACC_W-1:0]   acc_q, acc_d, acc_sum;
  logic [3:0]         cnt_q, cnt_d, grp_last;
  logic               push_req;
  logic [DATA_W-1:0]  push_data;

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   level_q;
  logic               ovf_q;
  logic               full, pop, push_ok, drop;

  // n_act_q is never 0 (0 is mapped to 1 when applied), so N-1 is safe.
  assign phase_end = (div_cnt_q == n_act_q - 1'b1);
  assign cfg_take  = apply_cfg & pend_vld_q;

  // State register plus divider counter and registered sample clock.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state_q   <= S_IDLE;
      div_cnt_q <= '0;
      adc_clk_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      adc_clk_q <= (state_d == S_HIGH);
    end
  end

  // Next-state logic; a period always runs to completion once started.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (I_enable)  state_d = S_HIGH;
      S_HIGH:  if (phase_end) state_d = S_LOW;
      S_LOW:   if (phase_end) state_d = I_enable ? S_HIGH : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Per-state outputs: divider count, sample strobe and period-boundary events.
  always_comb begin
    div_cnt_d = '0;
    strobe    = 1'b0;
    apply_cfg = 1'b0;
    to_idle   = 1'b0;
    unique case (state_q)
      S_IDLE: apply_cfg = I_enable;
      S_HIGH: begin
        strobe    = phase_end;
        div_cnt_d = phase_end ? '0 : div_cnt_q + 1'b1;
      end
      S_LOW: begin
        div_cnt_d = phase_end ? '0 : div_cnt_q + 1'b1;
        apply_cfg = phase_end;
        to_idle   = phase_end & ~I_enable;
      end
      default: div_cnt_d = '0;
    endcase
  end

  // Pending/active configuration; a strobe arriving on a boundary stays pending.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      n_act_q    <= DIV_W'(1);
      a_act_q    <= 2'd0;
      pend_n_q   <= '0;
      pend_a_q   <= 2'd0;
      pend_vld_q <= 1'b0;
    end else begin
      if (cfg_take) begin
        n_act_q <= (pend_n_q == '0) ? DIV_W'(1) : pend_n_q;
        a_act_q <= pend_a_q;
      end
      if (I_cfg_valid) begin
        pend_n_q   <= I_div_setting;
        pend_a_q   <= I_avg_log2;
        pend_vld_q <= 1'b1;
      end else if (cfg_take) begin
        pend_vld_q <= 1'b0;
      end
    end
  end

  // Capture ADC data on the last high cycle of the sample clock.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      sample_q     <= '0;
      sample_vld_q <= 1'b0;
    end else begin
      sample_vld_q <= strobe;
      if (strobe) sample_q <= I_adc_data;
    end
  end

  // Averager: a completed group is pushed even if a clear lands on the same cycle.
  always_comb begin
    grp_last  = (4'd1 << a_act_q) - 4'd1;
    acc_sum   = acc_q + ACC_W'(sample_q);
    push_data = DATA_W'(acc_sum >> a_act_q);
    push_req  = 1'b0;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    if (sample_vld_q) begin
      if (cnt_q == grp_last) begin
        push_req = 1'b1;
        acc_d    = '0;
        cnt_d    = '0;
      end else begin
        acc_d = acc_sum;
        cnt_d = cnt_q + 4'd1;
      end
    end
    if (to_idle || cfg_take) begin
      acc_d = '0;
      cnt_d = '0;
    end
  end

  // Accumulator and sample-count registers.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign full    = (level_q == (FIFO_AW+1)'(DEPTH));
  assign pop     = (level_q != '0) & I_rd_ready;
  assign push_ok = push_req & (~full | pop);
  assign drop    = push_req & full & ~pop;

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge I_clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_data;
  end

  // FIFO pointers, occupancy and sticky overflow (a new drop beats a clear).
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !pop)      level_q <= level_q + 1'b1;
      else if (!push_ok && pop) level_q <= level_q - 1'b1;
      if (drop)                ovf_q <= 1'b1;
      else if (I_clr_overflow) ovf_q <= 1'b0;
    end
  end

  assign O_adc_clk    = adc_clk_q;
  assign O_rd_valid   = (level_q != '0);
  assign O_rd_data    = O_rd_valid ? mem[rd_ptr_q] : '0;
  assign O_fifo_level = level_q;
  assign O_overflow   = ovf_q;

endmodule

// File: doc/adc_capture_engine.md
# adc_capture_engine

Parametrised ADC front-end for the solar sampling path. It generates a programmable ADC sample clock, captures ADC data once per period, and can average 1/2/4/8 samples per result. Results go into a synchronous first-word-fall-through FIFO with a valid/ready read port and sticky overflow reporting. It sits between the external ADC pins and the UART packetiser, all in the system clock domain.

## Interface
- DATA_W, 12: ADC sample width.
- DIV_W, 16: width of the half-period divider setting.
- FIFO_AW, 4: FIFO address width; depth = 2^FIFO_AW.
- I_clk  in  1  system clock; all logic is on its rising edge.
- I_rst  in  1  asynchronous active-high reset.
- I_enable  in  1  run capture when 1.
- I_adc_data  in  DATA_W  ADC parallel output bus.
- I_div_setting  in  DIV_W  half-period N in I_clk cycles; 0 is treated as 1.
- I_avg_log2  in  2  averaging count A; results average 2^A samples.
- I_cfg_valid  in  1  1-cycle strobe that latches I_div_setting and I_avg_log2 as pending.
- I_rd_ready  in  1  consumer accepts the head word.
- I_clr_overflow  in  1  clear the sticky overflow flag.
- O_adc_clk  out  1  ADC sample clock (registered, glitch-free).
- O_rd_valid  out  1  FIFO non-empty.
- O_rd_data  out  DATA_W  FIFO head word, valid while O_rd_valid=1.
- O_fifo_level  out  FIFO_AW+1  current FIFO occupancy, 0..2^FIFO_AW.
- O_overflow  out  1  sticky: a result was dropped because the FIFO was full.

## Operation
- Reset values: O_adc_clk=0, O_rd_valid=0, O_rd_data=0, O_fifo_level=0, O_overflow=0. Active N=1, A=0; no pending config; FSM in IDLE; accumulator=0; sample count=0.
- FSM states:
  - IDLE: O_adc_clk held 0; divider counter held 0.
  - HIGH: O_adc_clk=1 for N cycles.
  - LOW: O_adc_clk=0 for N cycles.
- FSM transitions:
  - IDLE→HIGH: on the cycle after I_enable is sampled as 1.
  - HIGH→LOW: at the end of N cycles.
  - LOW→HIGH: at the end of N cycles if I_enable=1.
  - LOW→IDLE: at the end of N cycles if I_enable=0.
  - Deasserting I_enable never truncates a running period.
- Config:
  - I_cfg_valid copies both inputs into pending registers; a later strobe overwrites an earlier one.
  - Pending config becomes active only at a period boundary: the end of LOW, or on entering HIGH from IDLE.
  - When config is applied, the accumulator and sample count are cleared.
- Sample strobe: asserted on the last cycle of HIGH (the cycle before O_adc_clk falls). I_adc_data is registered at the end of that cycle.
- Averaging:
  - The accumulator is DATA_W+3 bits and is unsigned.
  - After 2^A samples, result = acc >> A, truncated to DATA_W bits; a push is issued; accumulator and count are cleared.
  - A=0 passes each raw sample straight through.
- Partial averages:
  - On the transition to IDLE, any partial accumulation is discarded.
  - After I_rst, no partial result is ever pushed.
- FIFO:
  - Depth 2^FIFO_AW, first-word-fall-through.
  - A pop occurs when O_rd_valid & I_rd_ready.
  - A push is accepted if the FIFO is not full, or if a pop happens in the same cycle.
  - Otherwise the result is dropped and O_overflow is set.
  - Pointers wrap modulo 2^FIFO_AW.
  - O_fifo_level: +1 on a push alone, −1 on a pop alone, unchanged when both occur.
- Overflow: if I_clr_overflow and a new drop happen in the same cycle, the flag is set (set wins).
- A pop with O_rd_valid=0 is ignored; O_fifo_level never underflows.
- I_rst asserted mid-operation: all state returns to reset values immediately (asynchronously). FIFO contents are discarded.

## Timing
- O_adc_clk period = 2N I_clk cycles at 50% duty; it changes only on I_clk edges.
- I_enable rising at cycle t (sampled at the edge ending t): O_adc_clk=1 from t+1.
- Strobe at cycle s completing a result: the word is written at the end of s+1. O_rd_valid=1 and O_rd_data are valid from s+2 if the FIFO was empty.
- Pop at cycle p: the next head word (or O_rd_valid=0) is presented from p+1.
- O_overflow rises in the cycle after the dropped push attempt.
- O_fifo_level updates in the cycle after the push or pop.
- Throughput: at most one result per 2N·2^A cycles; with N=1 the FIFO sees at most one push every 2 cycles.

## Test plan
- N=2, A=0, enable, I_adc_data ramps 0,1,2…, I_rd_ready=1:
  - O_adc_clk period is 4 cycles, high 2, starting 1 cycle after enable.
  - Output words are the values present on the last high cycle.
  - First O_rd_valid occurs 2 cycles after the first strobe.
- N=1, A=2, samples 10,11,12,13 then 100,100,100,103 → outputs 11, then 100 (truncation).
  - Disable after 2 samples of a third group → no third output.
- FIFO_AW=4, I_rd_ready=0, 20 results → O_fifo_level saturates at 16, O_overflow=1, and the first 16 words are read back intact.
  - Pulse I_clr_overflow during a drop → flag stays 1.
  - Pulse it with no drop → flag clears.
- FIFO full with I_rd_ready=1 in the same cycle as a push → push accepted, O_fifo_level stays 16, O_overflow stays 0.
- I_cfg_valid with N=5 mid-HIGH while N=2 → the current 4-cycle period completes, then a 10-cycle period follows.
  - Two strobes before the boundary → the last one wins.
  - I_div_setting=0 → period 2.
- Assert I_rst mid-HIGH with 3 words queued → all outputs go to 0 immediately; after release with enable held, capture restarts from IDLE and the FIFO is empty.
